// File: rtl/seg_blink_ctrl.sv
// Seven-segment / LED / switch peripheral with hex decode and per-digit hardware blinking.
// Define SEG_CTRL_DEBOUNCE_EN to add per-switch debounce counters clocked by the blink tick.
module seg_blink_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int NUM_LEDS       = 8,
    parameter int NUM_SW         = 4,
    parameter int PRESCALE       = 50000,
    parameter int DEBOUNCE_TICKS = 20
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [3:0]              addr,
    input  logic [31:0]             wr_data,
    output logic [31:0]             rd_data,
    output logic [8*NUM_DIGITS-1:0] seg_out,
    output logic [NUM_LEDS-1:0]     led_out,
    input  logic [NUM_SW-1:0]       sw_in
);

    localparam logic [3:0] ADDR_MASK = 4'd8;
    localparam logic [3:0] ADDR_HALF = 4'd9;
    localparam logic [3:0] ADDR_CTRL = 4'd10;
    localparam logic [3:0] ADDR_LED  = 4'd11;
    localparam logic [3:0] ADDR_SW   = 4'd12;
    localparam int         PW        = $clog2(PRESCALE);

    logic [1:0]              rst_sync_q;
    logic                    rst_n;

    logic [5:0]              digit_q [NUM_DIGITS];
    logic [5:0]              digit_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [15:0]             half_q, half_d;
    logic                    ctrl_en_q, ctrl_en_d;
    logic [NUM_LEDS-1:0]     led_q, led_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    phase_q, phase_d;
    logic [31:0]             rd_data_q, rd_data_d;
    logic [8*NUM_DIGITS-1:0] seg_q, seg_d;
    logic [NUM_SW-1:0]       sync1_q, sync2_q;
    logic [NUM_SW-1:0]       sw_state;
    logic                    tick;
    logic                    half_wr;
    logic [31:0]             rd_mux;
    logic                    unused_wr;

    assign unused_wr = ^wr_data[31:16];

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) rst_sync_q <= 2'b00;
        else                rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    function automatic logic [7:0] hex_decode(input logic [3:0] v);
        case (v)
            4'h0: hex_decode = 8'hC0;
            4'h1: hex_decode = 8'hF9;
            4'h2: hex_decode = 8'hA4;
            4'h3: hex_decode = 8'hB0;
            4'h4: hex_decode = 8'h99;
            4'h5: hex_decode = 8'h92;
            4'h6: hex_decode = 8'h82;
            4'h7: hex_decode = 8'hF8;
            4'h8: hex_decode = 8'h80;
            4'h9: hex_decode = 8'h90;
            4'hA: hex_decode = 8'h88;
            4'hB: hex_decode = 8'h83;
            4'hC: hex_decode = 8'hC6;
            4'hD: hex_decode = 8'hA1;
            4'hE: hex_decode = 8'h86;
            default: hex_decode = 8'h8E;
        endcase
    endfunction

    always_comb begin
        digit_d   = digit_q;
        mask_d    = mask_q;
        half_d    = half_q;
        ctrl_en_d = ctrl_en_q;
        led_d     = led_q;
        if (wr_en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (addr == 4'(i)) digit_d[i] = wr_data[5:0];
            end
            case (addr)
                ADDR_MASK: mask_d    = wr_data[NUM_DIGITS-1:0];
                ADDR_HALF: half_d    = wr_data[15:0];
                ADDR_CTRL: ctrl_en_d = wr_data[0];
                ADDR_LED:  led_d     = wr_data[NUM_LEDS-1:0];
                default:   ;
            endcase
        end
    end

    // A BLINK_HALF write restarts the whole blink timebase in the visible phase.
    assign half_wr = wr_en && (addr == ADDR_HALF);
    assign tick    = (presc_q == PW'(PRESCALE - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (half_wr) begin
            presc_d = '0;
            cnt_d   = 16'd0;
            phase_d = 1'b1;
        end else if (half_q == 16'd0) begin
            cnt_d   = 16'd0;
            phase_d = 1'b1;
        end else if (tick) begin
            if (cnt_q == half_q - 16'd1) begin
                cnt_d   = 16'd0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (addr == 4'(i)) rd_mux[5:0] = digit_q[i];
        end
        case (addr)
            ADDR_MASK: rd_mux[NUM_DIGITS-1:0] = mask_q;
            ADDR_HALF: rd_mux[15:0]           = half_q;
            ADDR_CTRL: rd_mux[0]              = ctrl_en_q;
            ADDR_LED:  rd_mux[NUM_LEDS-1:0]   = led_q;
            ADDR_SW:   rd_mux[NUM_SW-1:0]     = sw_state;
            default:   ;
        endcase
        rd_data_d = rd_en ? rd_mux : rd_data_q;
    end

    always_comb begin
        seg_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!digit_q[i][5] && ctrl_en_q && !(mask_q[i] && !phase_q)) begin
                seg_d[8*i +: 8]    = hex_decode(digit_q[i][3:0]);
                seg_d[8*i + 7]     = ~digit_q[i][4];
            end
        end
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= 6'h20;
            mask_q    <= '0;
            half_q    <= 16'd0;
            ctrl_en_q <= 1'b1;
            led_q     <= '0;
            presc_q   <= '0;
            cnt_q     <= 16'd0;
            phase_q   <= 1'b1;
            rd_data_q <= 32'd0;
            seg_q     <= '1;
            sync1_q   <= '0;
            sync2_q   <= '0;
        end else begin
            digit_q   <= digit_d;
            mask_q    <= mask_d;
            half_q    <= half_d;
            ctrl_en_q <= ctrl_en_d;
            led_q     <= led_d;
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            rd_data_q <= rd_data_d;
            seg_q     <= seg_d;
            sync1_q   <= sw_in;
            sync2_q   <= sync1_q;
        end
    end

`ifdef SEG_CTRL_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);

    logic [NUM_SW-1:0] sw_q, sw_d;
    logic [DBW-1:0]    db_cnt_q [NUM_SW];
    logic [DBW-1:0]    db_cnt_d [NUM_SW];

    // A bit flips only after DEBOUNCE_TICKS consecutive ticks of disagreement.
    always_comb begin
        sw_d     = sw_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < NUM_SW; i++) begin
            if (sync2_q[i] == sw_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (tick) begin
                if (db_cnt_q[i] == DBW'(DEBOUNCE_TICKS - 1)) begin
                    sw_d[i]     = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_q <= '0;
            for (int i = 0; i < NUM_SW; i++) db_cnt_q[i] <= '0;
        end else begin
            sw_q     <= sw_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign sw_state = sw_q;
`else
    localparam int UNUSED_DB = DEBOUNCE_TICKS;
    assign sw_state = sync2_q;
`endif

    assign rd_data = rd_data_q;
    assign seg_out = seg_q;
    assign led_out = led_q;

endmodule

// File: tb/tb_seg_blink_ctrl.sv
// Scoreboard testbench for seg_blink_ctrl: expectations are queued when stimulus is
// driven and popped when the corresponding DUT output becomes valid.
module tb_seg_blink_ctrl;

    localparam int ND = 4;
    localparam int NL = 8;
    localparam int NS = 4;

    logic            clock = 1'b0;
    logic            reset_reset_n;
    logic            wr_en, rd_en;
    logic [3:0]      addr;
    logic [31:0]     wr_data;
    logic [31:0]     rd_data;
    logic [8*ND-1:0] seg_out;
    logic [NL-1:0]   led_out;
    logic [NS-1:0]   sw_in;

    int          vectorCount = 0;
    int          missCount   = 0;
    logic [31:0] expQ[$];
    string       tagQ[$];
    logic [7:0]  hexTable [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always #5 clock = ~clock;

    seg_blink_ctrl #(
        .NUM_DIGITS(ND), .NUM_LEDS(NL), .NUM_SW(NS), .PRESCALE(4), .DEBOUNCE_TICKS(3)
    ) dut (
        .clk_clk(clock), .reset_reset_n(reset_reset_n), .wr_en(wr_en), .rd_en(rd_en),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .seg_out(seg_out),
        .led_out(led_out), .sw_in(sw_in)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic pushExpect(input string tag, input logic [31:0] value);
        tagQ.push_back(tag);
        expQ.push_back(value);
    endtask

    task automatic popCompare(input logic [31:0] observed);
        if (expQ.size() == 0) checkOutput("scoreboard_underflow", 32'(expQ.size()), 32'd1);
        else checkOutput(tagQ.pop_front(), observed, expQ.pop_front());
    endtask

    // One bus cycle: drive on the falling edge, return 1 time unit after the rising edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        wr_en = w; rd_en = r; addr = a; wr_data = d;
        @(posedge clock);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic writeReg(input logic [3:0] a, input logic [31:0] d);
        applyStimulus(1'b1, 1'b0, a, d);
    endtask

    task automatic readReg(input string tag, input logic [3:0] a, input logic [31:0] expected);
        pushExpect(tag, expected);
        applyStimulus(1'b0, 1'b1, a, 32'd0);
        popCompare(rd_data);
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic checkSeg(input string tag, input logic [31:0] expected);
        pushExpect(tag, expected);
        popCompare(seg_out);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_reset_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; addr = 4'd0; wr_data = 32'd0; sw_in = '0;
        repeat (3) @(posedge clock);
        #1;
        checkSeg("reset_seg", 32'hFFFF_FFFF);
        pushExpect("reset_led", 32'd0);  popCompare(32'(led_out));
        pushExpect("reset_rd", 32'd0);   popCompare(rd_data);
        @(negedge clock);
        reset_reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        readReg("reset_digit0", 4'd0, 32'h20);
        readReg("reset_ctrl", 4'd10, 32'h1);
        readReg("reset_half", 4'd9, 32'h0);

        // Basic decode and write-to-output latency
        writeReg(4'd0, 32'h03);
        writeReg(4'd1, 32'h1A);
        checkSeg("digit1_latency", 32'hFFFF_FFB0);
        nextCycle();
        checkSeg("digit01", 32'hFFFF_08B0);

        for (int v = 0; v < 16; v++) begin
            writeReg(4'd0, 32'(v));
            nextCycle();
            pushExpect($sformatf("decode_%0h", v), {24'd0, hexTable[v]});
            popCompare({24'd0, seg_out[7:0]});
        end
        writeReg(4'd2, 32'h1F);
        nextCycle();
        checkSeg("digit2_dp", 32'hFF0E_088E);
        writeReg(4'd2, 32'h20);

        // Blink: 12 cycles visible, 12 blank, starting visible after the BLINK_HALF write
        writeReg(4'd0, 32'h08);
        writeReg(4'd8, 32'h1);
        writeReg(4'd9, 32'd3);
        for (int k = 1; k <= 25; k++) begin
            nextCycle();
            if (k == 1 || k == 12 || k == 13 || k == 24 || k == 25) begin
                pushExpect($sformatf("blink_k%0d", k), (k >= 13 && k <= 24) ? 32'hFF : 32'h80);
                popCompare({24'd0, seg_out[7:0]});
            end
            if (k == 13) begin
                pushExpect("blink_other_digit", 32'h08);
                popCompare({24'd0, seg_out[15:8]});
            end
        end
        writeReg(4'd9, 32'd0);
        repeat (20) nextCycle();
        checkSeg("blink_off_visible", 32'hFFFF_0880);

        // Display enable
        writeReg(4'd11, 32'hA5);
        writeReg(4'd10, 32'h0);
        nextCycle();
        checkSeg("ctrl_off", 32'hFFFF_FFFF);
        pushExpect("ctrl_off_led", 32'hA5); popCompare(32'(led_out));
        writeReg(4'd10, 32'h1);
        checkSeg("ctrl_on_latency", 32'hFFFF_FFFF);
        nextCycle();
        checkSeg("ctrl_on", 32'hFFFF_0880);

        // Register reads
        readReg("read_led", 4'd11, 32'hA5);
        readReg("read_unused13", 4'd13, 32'h0);
        readReg("read_led2", 4'd11, 32'hA5);
        writeReg(4'd11, 32'h5A);
        pushExpect("rd_hold", 32'hA5); popCompare(rd_data);
        pushExpect("rdwr_same_addr", 32'h5A);
        applyStimulus(1'b1, 1'b1, 4'd11, 32'h3C);
        popCompare(rd_data);
        readReg("read_led_new", 4'd11, 32'h3C);
        pushExpect("led_new", 32'h3C); popCompare(32'(led_out));
        writeReg(4'd8, 32'hFFFF_FFFF);
        readReg("mask_high_bits", 4'd8, 32'hF);
        writeReg(4'd8, 32'h0);
        writeReg(4'd5, 32'h00);
        readReg("digit5_ignored", 4'd5, 32'h0);
        checkSeg("digit5_no_effect", 32'hFFFF_0880);
        readReg("read_unused15", 4'd15, 32'h0);

        // Switch conditioning
`ifndef SEG_CTRL_DEBOUNCE_EN
        sw_in = 4'b0001;
        readReg("sw_edge1", 4'd12, 32'h0);
        readReg("sw_edge2", 4'd12, 32'h0);
        readReg("sw_edge3", 4'd12, 32'h1);
        sw_in = 4'b1010;
        readReg("sw2_edge1", 4'd12, 32'h1);
        readReg("sw2_edge2", 4'd12, 32'h1);
        readReg("sw2_edge3", 4'd12, 32'hA);
`else
        sw_in = 4'b0001;
        repeat (5) nextCycle();
        sw_in = 4'b0000;
        repeat (30) nextCycle();
        readReg("sw_glitch_ignored", 4'd12, 32'h0);
        sw_in = 4'b0001;
        repeat (30) nextCycle();
        readReg("sw_held", 4'd12, 32'h1);
        sw_in = 4'b1010;
        repeat (30) nextCycle();
        readReg("sw_held2", 4'd12, 32'hA);
`endif

        // Reset in the middle of the blank phase
        writeReg(4'd0, 32'h08);
        writeReg(4'd8, 32'h1);
        writeReg(4'd9, 32'd3);
        repeat (14) nextCycle();
        pushExpect("pre_reset_blank", 32'hFF); popCompare({24'd0, seg_out[7:0]});
        #1;
        reset_reset_n = 1'b0;
        #1;
        checkSeg("async_reset_seg", 32'hFFFF_FFFF);
        pushExpect("async_reset_rd", 32'd0);  popCompare(rd_data);
        pushExpect("async_reset_led", 32'd0); popCompare(32'(led_out));
        @(negedge clock);
        reset_reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        readReg("post_reset_mask", 4'd8, 32'h0);
        readReg("post_reset_half", 4'd9, 32'h0);
        checkSeg("post_reset_seg", 32'hFFFF_FFFF);
        writeReg(4'd0, 32'h08);
        writeReg(4'd8, 32'h1);
        nextCycle();
        checkSeg("post_reset_phase1", 32'hFFFF_FF80);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
